// File: rtl/en2pulse_if.sv
// Start/timing request and pulse status bundle between the bit serializer and en2pulse.
// The serializer is the master; en2pulse is the slave.
interface en2pulse_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 start_in;
  logic [CNT_WIDTH-1:0] high_cnt_in;
  logic [CNT_WIDTH-1:0] low_cnt_in;
  logic                 level_out;
  logic                 busy_out;
  logic                 ready_out;
  logic                 done_out;

  modport master (
    output start_in, high_cnt_in, low_cnt_in,
    input  level_out, busy_out, ready_out, done_out
  );

  modport slave (
    input  start_in, high_cnt_in, low_cnt_in,
    output level_out, busy_out, ready_out, done_out
  );
endinterface

// File: rtl/en2pulse.sv
// Turns a one-cycle start into a timed level pulse: HIGH for H cycles, then LOW for L cycles.
// Define EN2PULSE_RETRIG_EN to let a start during an active slot abort it and restart at once.
module en2pulse #(
  parameter int CNT_WIDTH = 8
) (
  input  logic     clk_in,
  input  logic     rst_n_in,
  en2pulse_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] low_q, low_d;
  logic                 level_q, level_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pend_q, pend_d;

  logic final_cycle;
  logic ready;
  logic accept;
  logic zero_slot;
  logic aborted;

  // Last active cycle of a slot: a new start here chains on with no idle gap.
  always_comb begin
    final_cycle = ((state_q == HIGH) && (cnt_q == CNT_ZERO) && (low_q == CNT_ZERO)) ||
                  ((state_q == LOW)  && (cnt_q == CNT_ZERO));
`ifdef EN2PULSE_RETRIG_EN
    ready = 1'b1;
`else
    ready = (state_q == IDLE) || final_cycle;
`endif
    accept    = bus.start_in && ready;
    zero_slot = accept && (bus.high_cnt_in == CNT_ZERO) && (bus.low_cnt_in == CNT_ZERO);
    aborted   = accept && (state_q != IDLE) && !final_cycle;
  end

  // NOTE: every variable written in this block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    low_d   = low_q;

    unique case (state_q)
      HIGH: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (low_q != CNT_ZERO) begin
          state_d = LOW;
          cnt_d   = low_q - CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      LOW: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // A fresh slot overrides whatever the running slot would have done at this edge.
    if (accept) begin
      low_d = bus.low_cnt_in;
      if (bus.high_cnt_in != CNT_ZERO) begin
        state_d = HIGH;
        cnt_d   = bus.high_cnt_in - CNT_ONE;
      end else if (bus.low_cnt_in != CNT_ZERO) begin
        state_d = LOW;
        cnt_d   = bus.low_cnt_in - CNT_ONE;
      end else begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    end

    level_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);

    // A zero-length slot accepted on the edge where another slot ends would collide with that
    // slot's done; defer it one cycle so every accepted start still gets exactly one done.
    done_d = final_cycle || pend_q || (zero_slot && !final_cycle && !pend_q);
    pend_d = zero_slot && (final_cycle || pend_q);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      low_q   <= CNT_ZERO;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy_out  = busy_q;
  assign bus.ready_out = ready;
  assign bus.done_out  = done_q;

  // Structural invariants of the slot engine.
  a_level_busy : assert property (@(posedge clk_in) disable iff (!rst_n_in) level_q |-> busy_q);
  a_idle_cnt   : assert property (@(posedge clk_in) disable iff (!rst_n_in)
                                  (state_q == IDLE) |-> (cnt_q == CNT_ZERO));
  a_abort_kind : assert property (@(posedge clk_in) disable iff (!rst_n_in)
                                  aborted |-> (state_q inside {HIGH, LOW}));

endmodule

// File: tb/tb_en2pulse.sv
// Scoreboard bench for en2pulse: a slot-level model predicts done timing and phase lengths,
// a monitor checks them, and directed runs check cycle-exact traces.
module tb_en2pulse;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  en2pulse_if #(.CNT_WIDTH(W)) bus ();

  en2pulse #(.CNT_WIDTH(W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
    int dc;
  } slot_t;

  slot_t sb[$];
  slot_t m_exp;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int m_rem    = 0;   // active cycles left in the current slot, counting the present one
  int acc_h    = 0;
  int acc_l    = 0;
  bit order_bad = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Reference model: a slot occupies H+L cycles from the accept edge; done lands right after.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_rem = 0;
    end else begin
      bit acc;
      int h;
      int l;
      h = int'(bus.high_cnt_in);
      l = int'(bus.low_cnt_in);
`ifdef EN2PULSE_RETRIG_EN
      acc = bus.start_in;
`else
      acc = bus.start_in && (m_rem <= 1);
`endif
      if (acc) begin
`ifdef EN2PULSE_RETRIG_EN
        if (m_rem > 1) void'(sb.pop_back());
`endif
        sb.push_back('{h: h, l: l, dc: cyc + h + l});
        m_rem = h + l;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
  end

  // Monitor: per-cycle ready check, phase accounting, and scoreboard pop on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_h = 0;
      acc_l = 0;
      order_bad = 1'b0;
    end else begin
`ifdef EN2PULSE_RETRIG_EN
      check("ready", int'(bus.ready_out), 1);
`else
      check("ready", int'(bus.ready_out), int'(m_rem <= 1));
`endif
      check("level_implies_busy", int'(bus.level_out & ~bus.busy_out), 0);
      if (bus.done_out) begin
        if (sb.size() == 0) begin
          check("done_unexpected_queue", sb.size(), 1);
        end else begin
          m_exp = sb.pop_front();
          check("done_time", cyc, m_exp.dc);
          check("high_cycles", acc_h, m_exp.h);
          check("low_cycles", acc_l, m_exp.l);
          check("high_before_low", int'(order_bad), 0);
        end
        acc_h = 0;
        acc_l = 0;
        order_bad = 1'b0;
      end else if (sb.size() > 0 && sb[0].dc < cyc) begin
        check("done_missing", int'(bus.done_out), 1);
        void'(sb.pop_front());
        acc_h = 0;
        acc_l = 0;
        order_bad = 1'b0;
      end
      if (bus.busy_out) begin
        if (bus.level_out) begin
          if (acc_l > 0) order_bad = 1'b1;
          acc_h++;
        end else begin
          acc_l++;
        end
      end
    end
  end

  // One isolated slot from idle, with a cycle-exact trace check.
  task automatic run_slot(input int h, input int l);
    @(posedge clk); #1;
    bus.start_in    = 1'b1;
    bus.high_cnt_in = W'(h);
    bus.low_cnt_in  = W'(l);
    @(posedge clk); #1;
    bus.start_in    = 1'b0;
    bus.high_cnt_in = W'($urandom);
    bus.low_cnt_in  = W'($urandom);
    for (int k = 0; k <= h + l; k++) begin
      @(negedge clk);
      check("slot_level", int'(bus.level_out), int'(k < h));
      check("slot_busy",  int'(bus.busy_out),  int'(k < h + l));
      check("slot_done",  int'(bus.done_out),  int'(k == h + l));
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bus.start_in    = 1'b0;
    bus.high_cnt_in = '0;
    bus.low_cnt_in  = '0;

    #12;
    check("reset_level", int'(bus.level_out), 0);
    check("reset_busy",  int'(bus.busy_out),  0);
    check("reset_done",  int'(bus.done_out),  0);
    check("reset_ready", int'(bus.ready_out), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic slot and the degenerate shapes.
    run_slot(3, 5);
    run_slot(0, 4);
    run_slot(2, 0);
    run_slot(0, 0);
    run_slot(1, 1);

    // Held start: back-to-back 3/5 slots with no gap.
    @(posedge clk); #1;
    bus.start_in    = 1'b1;
    bus.high_cnt_in = W'(3);
    bus.low_cnt_in  = W'(5);
    repeat (40) @(posedge clk);
    #1 bus.start_in = 1'b0;
    repeat (12) @(posedge clk);

    // Start during HIGH cycle 2 of a 4/4 slot.
    @(posedge clk); #1;
    bus.start_in    = 1'b1;
    bus.high_cnt_in = W'(4);
    bus.low_cnt_in  = W'(4);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    @(posedge clk); #1;
    bus.start_in    = 1'b1;
    bus.high_cnt_in = W'(2);
    bus.low_cnt_in  = W'(2);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in the middle of the LOW phase.
    @(posedge clk); #1;
    bus.start_in    = 1'b1;
    bus.high_cnt_in = W'(2);
    bus.low_cnt_in  = W'(6);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_level", int'(bus.level_out), 0);
    check("abort_busy",  int'(bus.busy_out),  0);
    check("abort_done",  int'(bus.done_out),  0);
    if (m_rem > 0) void'(sb.pop_back());
    m_rem = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_slot(1, 2);

    // Maximum phase lengths.
    run_slot(255, 255);

    // Random starts, including ones that land mid-slot or on the final cycle.
    repeat (600) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin
        int h;
        int l;
        h = $urandom_range(0, 6);
        l = $urandom_range(0, 6);
        if ($urandom_range(0, 9) == 0) h = $urandom_range(0, 40);
        if (h == 0 && l == 0 && m_rem != 0) l = 1;
        bus.start_in    = 1'b1;
        bus.high_cnt_in = W'(h);
        bus.low_cnt_in  = W'(l);
      end else begin
        bus.start_in    = 1'b0;
        bus.high_cnt_in = W'($urandom);
        bus.low_cnt_in  = W'($urandom);
      end
    end
    @(posedge clk); #1;
    bus.start_in = 1'b0;

    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
